tc4_accum_ctrl: RTL and testbench

Debounced pushbutton-driven 4-bit two's complement accumulator that produces the signed value `N` consumed by the two's complement to 7-segment display stage. The user sets a 4-bit operand on switches and presses Add or Sub. The block debounces the button, performs `N ± Operand` with 4-bit wrap, flags signed overflow, and holds the result for display.

---
 rtl/tc4_accum_ctrl_if.sv | 20 ++
 rtl/tc4_accum_ctrl.sv | 121 ++++++++++++
 tb/tb_tc4_accum_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/tc4_accum_ctrl_if.sv
// Switch/pushbutton inputs and accumulator outputs of tc4_accum_ctrl.
// The master side is the panel/bench and the slave side is the accumulator.
interface tc4_accum_ctrl_if;
    logic [3:0] Operand;
    logic       AddBtn_n;
    logic       SubBtn_n;
    logic [3:0] N;
    logic       Overflow;
    logic       OpDone;

    modport master (
        output Operand, AddBtn_n, SubBtn_n,
        input  N, Overflow, OpDone
    );

    modport slave (
        input  Operand, AddBtn_n, SubBtn_n,
        output N, Overflow, OpDone
    );
endinterface

// File: rtl/tc4_accum_ctrl.sv
// Debounced Add/Sub pushbutton control for a 4-bit two's complement accumulator.
// One operation is performed per debounced press; the result is held for display.
module tc4_accum_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             Clock,
    input  logic             Reset,
    tc4_accum_ctrl_if.slave  bus
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, EXECUTE, WAIT_RELEASE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   op_sub_q, op_sub_d;
    logic signed [3:0]      n_q, n_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;
    logic [1:0]             add_sync_q, sub_sync_q;
    logic                   add_pr, sub_pr, same_held;
    logic [4:0]             res;

    // Returns {overflow, sum}; subtraction is a + ~b + 1 with the carry dropped.
    function automatic logic [4:0] addsub(input logic signed [3:0] a,
                                          input logic signed [3:0] b,
                                          input logic sub);
        logic signed [3:0] b_eff;
        logic signed [3:0] r;
        logic              v;
        b_eff = sub ? ~b : b;
        r     = a + b_eff + {3'b000, sub};
        v     = (a[3] == b_eff[3]) && (r[3] != a[3]);
        return {v, r};
    endfunction

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            add_sync_q <= 2'b11;
            sub_sync_q <= 2'b11;
        end else begin
            add_sync_q <= {add_sync_q[0], bus.AddBtn_n};
            sub_sync_q <= {sub_sync_q[0], bus.SubBtn_n};
        end
    end

    assign add_pr    = ~add_sync_q[1];
    assign sub_pr    = ~sub_sync_q[1];
    assign same_held = op_sub_q ? (sub_pr && !add_pr) : (add_pr && !sub_pr);
    assign res       = addsub(n_q, bus.Operand, op_sub_q);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_sub_q <= 1'b0;
            n_q      <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_sub_q <= op_sub_d;
            n_q      <= n_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_sub_d = op_sub_q;
        n_d      = n_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (add_pr ^ sub_pr) begin
                    op_sub_d = sub_pr;
                    cnt_d    = '0;
                    state_d  = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!same_held) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = EXECUTE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EXECUTE: begin
                n_d     = res[3:0];
                ovf_d   = res[4];
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                // Any press restarts the release debounce, so a held button never repeats.
                if (add_pr || sub_pr) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.N        = n_q;
    assign bus.Overflow = ovf_q;
    assign bus.OpDone   = done_q;

endmodule

// File: tb/tb_tc4_accum_ctrl.sv
// Directed bench for tc4_accum_ctrl with DEBOUNCE_CYCLES = 4.
module tb_tc4_accum_ctrl;

    logic Clock;
    logic Reset;
    int   total = 0;
    int   bad   = 0;
    int   pulses;
    int   first;

    tc4_accum_ctrl_if bus();

    tc4_accum_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Steps edges from..to (sampling 1 time unit after each edge) and records OpDone pulses.
    task automatic watch(input int from, input int to);
        for (int e = from; e <= to; e++) begin
            @(posedge Clock);
            #1;
            if (bus.OpDone === 1'b1) begin
                pulses++;
                if (first == 0) first = e;
            end
        end
    endtask

    // Full press/hold/release cycle; the button goes low before edge 1.
    task automatic do_op(input string tag, input logic sub, input logic [3:0] op,
                         input logic [3:0] exp_n, input logic exp_ovf);
        bus.Operand = op;
        if (sub) bus.SubBtn_n = 1'b0;
        else     bus.AddBtn_n = 1'b0;
        pulses = 0;
        first  = 0;
        watch(1, 12);
        bus.AddBtn_n = 1'b1;
        bus.SubBtn_n = 1'b1;
        watch(13, 22);
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_edge"}, first, 8);
        chk({tag, "_N"}, bus.N, exp_n);
        chk({tag, "_ovf"}, bus.Overflow, exp_ovf);
    endtask

    initial begin
        Reset        = 1'b1;
        bus.Operand  = 4'd0;
        bus.AddBtn_n = 1'b1;
        bus.SubBtn_n = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_N", bus.N, 4'd0);
        chk("rst_ovf", bus.Overflow, 1'b0);
        chk("rst_done", bus.OpDone, 1'b0);
        Reset = 1'b0;

        // Add 3 held for 30 cycles: single update at edge 8, no repeat
        bus.Operand  = 4'b0011;
        bus.AddBtn_n = 1'b0;
        pulses = 0;
        first  = 0;
        watch(1, 30);
        chk("hold_pulses", pulses, 1);
        chk("hold_edge", first, 8);
        chk("hold_N", bus.N, 4'b0011);
        chk("hold_ovf", bus.Overflow, 1'b0);
        bus.AddBtn_n = 1'b1;
        watch(31, 40);
        chk("hold_release_pulses", pulses, 1);

        // Overflow sequence around 0111
        do_op("add4", 1'b0, 4'b0100, 4'b0111, 1'b0);
        do_op("add1_ovf", 1'b0, 4'b0001, 4'b1000, 1'b1);
        do_op("sub1_ovf", 1'b1, 4'b0001, 4'b0111, 1'b1);
        do_op("add_m1", 1'b0, 4'b1111, 4'b0110, 1'b0);

        // Bounce: low 3, high 1, low held; the op follows the second press
        bus.Operand  = 4'b0001;
        bus.AddBtn_n = 1'b0;
        pulses = 0;
        first  = 0;
        watch(1, 3);
        bus.AddBtn_n = 1'b1;
        watch(4, 4);
        bus.AddBtn_n = 1'b0;
        watch(5, 20);
        chk("bounce_pulses", pulses, 1);
        chk("bounce_edge", first, 12);
        chk("bounce_N", bus.N, 4'b0111);
        bus.AddBtn_n = 1'b1;
        watch(21, 30);

        // Both buttons together never start an operation
        bus.Operand  = 4'b0010;
        bus.AddBtn_n = 1'b0;
        bus.SubBtn_n = 1'b0;
        pulses = 0;
        first  = 0;
        watch(1, 14);
        bus.AddBtn_n = 1'b1;
        bus.SubBtn_n = 1'b1;
        watch(15, 20);
        chk("both_pulses", pulses, 0);
        chk("both_N", bus.N, 4'b0111);

        do_op("sub7", 1'b1, 4'b0111, 4'b0000, 1'b0);

        // 0 - (-8) = 1000 with overflow, then async reset while OpDone is high
        bus.Operand  = 4'b1000;
        bus.SubBtn_n = 1'b0;
        pulses = 0;
        first  = 0;
        watch(1, 8);
        chk("subm8_edge", first, 8);
        chk("subm8_N", bus.N, 4'b1000);
        chk("subm8_ovf", bus.Overflow, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_rst_N", bus.N, 4'd0);
        chk("async_rst_ovf", bus.Overflow, 1'b0);
        chk("async_rst_done", bus.OpDone, 1'b0);
        bus.SubBtn_n = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        pulses = 0;
        watch(1, 8);
        chk("post_rst_pulses", pulses, 0);

        // -8 - (-8) = 0 without overflow
        do_op("subm8_again", 1'b1, 4'b1000, 4'b1000, 1'b1);
        do_op("m8_minus_m8", 1'b1, 4'b1000, 4'b0000, 1'b0);

        // Reset mid-DEBOUNCE with the button held through deassertion
        do_op("add5", 1'b0, 4'b0101, 4'b0101, 1'b0);
        bus.Operand  = 4'b0001;
        bus.AddBtn_n = 1'b0;
        pulses = 0;
        first  = 0;
        watch(1, 4);
        chk("mid_db_no_op", pulses, 0);
        #2;
        Reset = 1'b1;
        #1;
        chk("mid_db_rst_N", bus.N, 4'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        pulses = 0;
        first  = 0;
        watch(1, 12);
        chk("held_rst_pulses", pulses, 1);
        chk("held_rst_edge", first, 8);
        chk("held_rst_N", bus.N, 4'b0001);
        chk("held_rst_ovf", bus.Overflow, 1'b0);
        bus.AddBtn_n = 1'b1;
        watch(13, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
